// File: rtl/fetch_unit_if.sv
// Fetch-unit control bus: run control, branch/halt decode, jump-table write
// port and the fetched-address / status readout.
interface fetch_unit_if;
  logic        Start;
  logic        Stall;
  logic        BranchEn;
  logic [7:0]  Jptr;
  logic        DoneIn;
  logic        LutWe;
  logic [7:0]  LutAddr;
  logic [9:0]  LutData;
  logic [9:0]  ProgCtr;
  logic        Valid;
  logic        Halted;
  logic [15:0] CycleCnt;

  modport master (
    output Start, Stall, BranchEn, Jptr, DoneIn, LutWe, LutAddr, LutData,
    input  ProgCtr, Valid, Halted, CycleCnt
  );

  modport slave (
    input  Start, Stall, BranchEn, Jptr, DoneIn, LutWe, LutAddr, LutData,
    output ProgCtr, Valid, Halted, CycleCnt
  );
endinterface

// File: rtl/fetch_unit.sv
// Program counter sequencer: IDLE/RUN/HALT control, jump-table branching
// through a 256-entry LUT and a saturating executed-cycle counter.
module fetch_unit (
  input logic         Clk,
  input logic         Reset,
  fetch_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t      state;
  logic [9:0]  prog_ctr;
  logic [15:0] cycle_cnt;
  logic        halted;
  logic        start_q;
  logic        start_armed;
  logic        start_rise;
  logic        lut_wr;
  logic [9:0]  jump_lut [256];

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  // A level held high across reset must drop low once before it can count
  // as a start edge, so the history register alone is not enough.
  assign start_rise = bus.Start && !start_q && start_armed;
  assign lut_wr     = bus.LutWe && ((state == IDLE) || (state == HALT));

  assign bus.ProgCtr  = prog_ctr;
  assign bus.CycleCnt = cycle_cnt;
  assign bus.Halted   = halted;
  assign bus.Valid    = (state == RUN) && !bus.Stall;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state       <= IDLE;
      prog_ctr    <= '0;
      cycle_cnt   <= '0;
      halted      <= 1'b0;
      start_q     <= 1'b0;
      start_armed <= 1'b0;
    end else begin
      start_q <= bus.Start;
      if (!bus.Start) start_armed <= 1'b1;
      case (state)
        IDLE, HALT: begin
          if (start_rise) begin
            state     <= RUN;
            prog_ctr  <= '0;
            cycle_cnt <= '0;
            halted    <= 1'b0;
          end
        end
        RUN: begin
          if (!bus.Stall) begin
            cycle_cnt <= sat_inc(cycle_cnt);
            // Halt wins over a same-cycle branch; PC stays on the halting instruction.
            if (bus.DoneIn) begin
              state  <= HALT;
              halted <= 1'b1;
            end else if (bus.BranchEn) begin
              prog_ctr <= jump_lut[bus.Jptr];
            end else begin
              prog_ctr <= prog_ctr + 10'd1;
            end
          end
        end
        default: begin
          state  <= IDLE;
          halted <= 1'b0;
        end
      endcase
    end
  end

  // Writes only land while not running, so the branch read always sees
  // the pre-edge contents.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < 256; i++) jump_lut[i] <= '0;
    end else if (lut_wr) begin
      jump_lut[bus.LutAddr] <= bus.LutData;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed scoreboard bench for fetch_unit: each issued instruction cycle
// queues its expected PC/count, a negedge monitor checks every Valid cycle.
module tb_fetch_unit;

  logic Clk = 1'b0;
  logic Reset;

  fetch_unit_if bus();

  fetch_unit dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [9:0]  pc;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every executed cycle must match the oldest queued expectation.
  always @(negedge Clk) begin
    if (bus.Valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", {31'd0, bus.Valid}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("exec_pc", {22'd0, bus.ProgCtr}, {22'd0, mon_e.pc});
        chk("exec_cnt", {16'd0, bus.CycleCnt}, {16'd0, mon_e.cnt});
      end
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic exec(input logic [9:0] pc, input logic [15:0] cnt,
                      input logic br = 1'b0, input logic [7:0] jp = 8'd0,
                      input logic done = 1'b0);
    exp_t e;
    e.pc  = pc;
    e.cnt = cnt;
    sb.push_back(e);
    bus.Stall    = 1'b0;
    bus.BranchEn = br;
    bus.Jptr     = jp;
    bus.DoneIn   = done;
    step();
    bus.BranchEn = 1'b0;
    bus.Jptr     = 8'd0;
    bus.DoneIn   = 1'b0;
  endtask

  task automatic start_run();
    bus.Start = 1'b0;
    step();
    bus.Start = 1'b1;
    step();
  endtask

  task automatic chk_halt(input string name, input logic [9:0] pc, input logic [15:0] cnt);
    chk({name, "_halted"}, {31'd0, bus.Halted}, 32'd1);
    chk({name, "_pc"}, {22'd0, bus.ProgCtr}, {22'd0, pc});
    chk({name, "_cnt"}, {16'd0, bus.CycleCnt}, {16'd0, cnt});
    chk({name, "_valid"}, {31'd0, bus.Valid}, 32'd0);
  endtask

  initial begin
    Reset        = 1'b0;
    bus.Start    = 1'b0;
    bus.Stall    = 1'b0;
    bus.BranchEn = 1'b0;
    bus.Jptr     = 8'd0;
    bus.DoneIn   = 1'b0;
    bus.LutWe    = 1'b0;
    bus.LutAddr  = 8'd0;
    bus.LutData  = 10'd0;

    #12;
    chk("rst_pc", {22'd0, bus.ProgCtr}, 32'd0);
    chk("rst_cnt", {16'd0, bus.CycleCnt}, 32'd0);
    chk("rst_halted", {31'd0, bus.Halted}, 32'd0);
    chk("rst_valid", {31'd0, bus.Valid}, 32'd0);
    step();
    Reset = 1'b1;
    step();

    // Load jump table while idle.
    bus.LutWe   = 1'b1;
    bus.LutAddr = 8'd3;
    bus.LutData = 10'h200;
    step();
    bus.LutAddr = 8'd1;
    bus.LutData = 10'h3FF;
    step();
    bus.LutWe = 1'b0;
    chk("idle_pc", {22'd0, bus.ProgCtr}, 32'd0);
    chk("idle_halted", {31'd0, bus.Halted}, 32'd0);

    // Straight-line run halting at PC 5.
    start_run();
    for (int i = 0; i < 5; i++) exec(10'(i), 16'(i));
    exec(10'd5, 16'd5, 1'b0, 8'd0, 1'b1);
    chk_halt("halt5", 10'd5, 16'd6);
    step();
    chk_halt("halt5_hold", 10'd5, 16'd6);

    // Branch through LUT[3]; a start edge and a LUT write during RUN are ignored.
    start_run();
    exec(10'd0, 16'd0);
    bus.Start = 1'b0;
    exec(10'd1, 16'd1);
    bus.Start = 1'b1;
    exec(10'd2, 16'd2, 1'b1, 8'd3);
    exec(10'h200, 16'd3);
    bus.LutWe   = 1'b1;
    bus.LutAddr = 8'd3;
    bus.LutData = 10'h155;
    exec(10'h201, 16'd4, 1'b0, 8'd0, 1'b1);
    bus.LutWe = 1'b0;
    chk_halt("halt201", 10'h201, 16'd5);

    // Halt and branch together: halt wins.
    start_run();
    for (int i = 0; i < 7; i++) exec(10'(i), 16'(i));
    exec(10'd7, 16'd7, 1'b1, 8'd3, 1'b1);
    chk_halt("halt7", 10'd7, 16'd8);

    // Stall at PC 4, then branch (old LUT[3]) and wrap from 1023.
    start_run();
    for (int i = 0; i < 4; i++) exec(10'(i), 16'(i));
    for (int k = 0; k < 3; k++) begin
      bus.Stall    = 1'b1;
      bus.BranchEn = 1'b1;
      bus.Jptr     = 8'd1;
      bus.DoneIn   = 1'b1;
      step();
      chk("stall_pc", {22'd0, bus.ProgCtr}, 32'd4);
      chk("stall_cnt", {16'd0, bus.CycleCnt}, 32'd4);
      chk("stall_valid", {31'd0, bus.Valid}, 32'd0);
      chk("stall_halted", {31'd0, bus.Halted}, 32'd0);
    end
    bus.Stall    = 1'b0;
    bus.BranchEn = 1'b0;
    bus.Jptr     = 8'd0;
    bus.DoneIn   = 1'b0;
    exec(10'd4, 16'd4);
    exec(10'd5, 16'd5, 1'b1, 8'd3);
    exec(10'h200, 16'd6, 1'b1, 8'd1);
    exec(10'h3FF, 16'd7);
    for (int i = 0; i < 9; i++) exec(10'(i), 16'(8 + i));
    chk("pre_reset_pc", {22'd0, bus.ProgCtr}, 32'd9);

    // Asynchronous abort mid-run with Start held high through reset.
    Reset     = 1'b0;
    bus.Start = 1'b1;
    #1;
    chk("abort_pc", {22'd0, bus.ProgCtr}, 32'd0);
    chk("abort_cnt", {16'd0, bus.CycleCnt}, 32'd0);
    chk("abort_valid", {31'd0, bus.Valid}, 32'd0);
    chk("abort_halted", {31'd0, bus.Halted}, 32'd0);
    chk("sb_drained", sb.size(), 32'd0);
    step();
    step();
    Reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("post_rst_pc", {22'd0, bus.ProgCtr}, 32'd0);
      chk("post_rst_halted", {31'd0, bus.Halted}, 32'd0);
    end

    // Cleared LUT: branch via entry 3 lands on 0.
    start_run();
    exec(10'd0, 16'd0, 1'b1, 8'd3);
    exec(10'd0, 16'd1, 1'b0, 8'd0, 1'b1);
    chk_halt("halt_cleared", 10'd0, 16'd2);

    step();
    chk("sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
